// File: rtl/div_unit_seq.sv
// Multi-cycle radix-2 restoring divider: signed/unsigned, one quotient bit per clock.
// Quotient feeds LO and remainder feeds HI; both hold from DONE until the next accepted start.
module div_unit_seq #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Handshake: start is honoured only while busy is low; the results are valid
  // in the single cycle done is high and stay stable until the next accepted start.

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dmag_q, dmag_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             dvd_neg;
  logic             dsr_neg;

  assign dvd_neg = is_signed & dividend[WIDTH-1];
  assign dsr_neg = is_signed & divisor[WIDTH-1];

  // Remainder stays below the divisor, so only the shifted value needs the extra bit.
  assign shifted = {rem_q, dvd_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dmag_q};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dmag_d  = dmag_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dz_d    = dz_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d   = dvd_neg ? -dividend : dividend;
          dmag_d  = dsr_neg ? -divisor : divisor;
          neg_q_d = dvd_neg ^ dsr_neg;
          neg_r_d = dvd_neg;
          rem_d   = '0;
          count_d = CW'(WIDTH);
          dz_d    = 1'b0;
          if (divisor == '0) begin
            quo_d   = '1;
            rmd_d   = dividend;
            dz_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        // Sign fix-up gives truncation toward zero; MIN / -1 wraps back to MIN.
        quo_d   = neg_q_q ? -dvd_q : dvd_q;
        rmd_d   = neg_r_q ? -rem_q : rem_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dmag_q  <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dmag_q  <= dmag_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dz_q    <= dz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dz_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_div_unit_seq.sv
// Bench for div_unit_seq: WIDTH=32 and WIDTH=8 instances against an arithmetic reference model.
module tb_div_unit_seq;

  localparam int EW = 129;

  logic        Clock;
  logic        clear_n;

  logic        s_start, s_is_signed, s_busy, s_done, s_dz;
  logic [31:0] s_dividend, s_divisor, s_q, s_r;
  logic [1:0]  s_dbg;

  logic        t_start, t_is_signed, t_busy, t_done, t_dz;
  logic [7:0]  t_dividend, t_divisor, t_q, t_r;
  logic [1:0]  t_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [EW-1:0] exp_q[$];

  div_unit_seq #(.WIDTH(32)) dut32 (
    .Clock(Clock), .clear_n(clear_n), .start(s_start), .is_signed(s_is_signed),
    .dividend(s_dividend), .divisor(s_divisor), .busy(s_busy), .done(s_done),
    .quotient(s_q), .remainder(s_r), .div_by_zero(s_dz), .dbg_state_o(s_dbg)
  );

  div_unit_seq #(.WIDTH(8)) dut8 (
    .Clock(Clock), .clear_n(clear_n), .start(t_start), .is_signed(t_is_signed),
    .dividend(t_dividend), .divisor(t_divisor), .busy(t_busy), .done(t_done),
    .quotient(t_q), .remainder(t_r), .div_by_zero(t_dz), .dbg_state_o(t_dbg)
  );

  // ---------------- clock ----------------
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division on sign- or zero-extended operands, {dz, rem, quo}.
  function automatic logic [EW-1:0] model(input int w, input bit sg,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mask, am, bm, q, r;
    longint sa, sb;
    mask = (64'd1 << w) - 64'd1;
    am = a & mask;
    bm = b & mask;
    if (bm == 64'd0) return {1'b1, am, mask};
    if (sg) begin
      sa = am[w-1] ? longint'(am | ~mask) : longint'(am);
      sb = bm[w-1] ? longint'(bm | ~mask) : longint'(bm);
      q = 64'(sa / sb);
      r = 64'(sa % sb);
    end else begin
      q = am / bm;
      r = am % bm;
    end
    return {1'b0, r & mask, q & mask};
  endfunction

  function automatic logic [63:0] cur_q(input bit w8);
    return w8 ? {56'd0, t_q} : {32'd0, s_q};
  endfunction
  function automatic logic [63:0] cur_r(input bit w8);
    return w8 ? {56'd0, t_r} : {32'd0, s_r};
  endfunction

  // ---------------- driver ----------------
  // poke > 0 pulses start with junk operands that many edges into the operation.
  task automatic do_div(input bit w8, input bit sg, input logic [63:0] a,
                        input logic [63:0] b, input int poke);
    int w, n, exp_lat;
    bit d, bz;
    logic [EW-1:0] e;
    w = w8 ? 8 : 32;
    bz = ((w8 ? (b & 64'hFF) : (b & 64'hFFFF_FFFF)) == 64'd0);
    exp_lat = bz ? 1 : w + 2;
    exp_q.push_back(model(w, sg, a, b));
    @(negedge Clock);
    if (w8) begin
      t_is_signed = sg; t_dividend = a[7:0]; t_divisor = b[7:0]; t_start = 1'b1;
    end else begin
      s_is_signed = sg; s_dividend = a[31:0]; s_divisor = b[31:0]; s_start = 1'b1;
    end
    n = 0;
    d = 1'b0;
    while (!d && n < 200) begin
      @(posedge Clock);
      n++;
      #1;
      if (n == 1) begin
        t_start = 1'b0;
        s_start = 1'b0;
        check_eq("busy_after_accept", {63'd0, w8 ? t_busy : s_busy}, 64'd1);
      end
      if (poke > 0 && n == poke) begin
        s_dividend = $urandom; s_divisor = $urandom | 32'd1; s_start = 1'b1;
      end else if (poke > 0 && n == poke + 1) begin
        s_start = 1'b0;
      end
      d = w8 ? t_done : s_done;
    end
    check_eq("done_seen", {63'd0, d}, 64'd1);
    e = exp_q.pop_front();
    check_eq("latency", 64'(n), 64'(exp_lat));
    check_eq("quotient", cur_q(w8), e[63:0]);
    check_eq("remainder", cur_r(w8), e[127:64]);
    check_eq("div_by_zero", {63'd0, w8 ? t_dz : s_dz}, {63'd0, e[128]});
    check_eq("busy_with_done", {63'd0, w8 ? t_busy : s_busy}, 64'd1);
    @(posedge Clock);
    #1;
    check_eq("done_pulse_end", {62'd0, w8 ? t_done : s_done, w8 ? t_busy : s_busy}, 64'd0);
    check_eq("quotient_hold", cur_q(w8), e[63:0]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] ra, rb;
    clear_n = 1'b0;
    s_start = 1'b0; s_is_signed = 1'b0; s_dividend = '0; s_divisor = '0;
    t_start = 1'b0; t_is_signed = 1'b0; t_dividend = '0; t_divisor = '0;
    repeat (3) @(posedge Clock);
    #1;
    check_eq("rst_outputs32", {s_q, s_r}, 64'd0);
    check_eq("rst_flags32", {61'd0, s_busy, s_done, s_dz}, 64'd0);
    check_eq("rst_outputs8", {48'd0, t_q, t_r}, 64'd0);
    check_eq("rst_flags8", {61'd0, t_busy, t_done, t_dz}, 64'd0);
    @(negedge Clock);
    clear_n = 1'b1;

    // Directed cases, WIDTH = 32
    do_div(0, 0, 64'h12, 64'h14, 0);
    do_div(0, 0, 64'd100, 64'd7, 0);
    do_div(0, 1, 64'hFFFF_FFF9, 64'd2, 0);
    do_div(0, 1, 64'd7, 64'hFFFF_FFFE, 0);
    do_div(0, 0, 64'h1234, 64'd0, 0);
    do_div(0, 0, 64'd50, 64'd5, 0);
    do_div(0, 1, 64'h8000_0000, 64'hFFFF_FFFF, 0);
    do_div(0, 1, 64'h8000_0000, 64'd1, 0);
    do_div(0, 0, 64'd1000, 64'd3, 5);

    // Reset in the middle of CALC discards the operation
    @(negedge Clock);
    s_is_signed = 1'b0; s_dividend = 32'd999; s_divisor = 32'd4; s_start = 1'b1;
    @(posedge Clock);
    #1 s_start = 1'b0;
    repeat (5) @(posedge Clock);
    #1 clear_n = 1'b0;
    #1;
    check_eq("midrst_results", {s_q, s_r}, 64'd0);
    check_eq("midrst_flags", {61'd0, s_busy, s_done, s_dz}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge Clock);
      #1 check_eq("midrst_no_done", {63'd0, s_done}, 64'd0);
    end
    @(negedge Clock);
    clear_n = 1'b1;
    do_div(0, 1, 64'hFFFF_FF9C, 64'd9, 0);

    // Directed cases, WIDTH = 8
    do_div(1, 0, 64'hFF, 64'h10, 0);
    do_div(1, 1, 64'h80, 64'h03, 0);
    do_div(1, 0, 64'h55, 64'h00, 0);
    do_div(1, 1, 64'h80, 64'hFF, 0);

    // Randomised cases on both widths
    for (int i = 0; i < 60; i++) begin
      ra = {32'd0, $urandom};
      case ($urandom_range(0, 3))
        0: rb = 64'd0;
        1: rb = 64'($urandom_range(1, 15));
        2: rb = {32'd0, $urandom};
        default: rb = ($urandom_range(0, 1) != 0) ? 64'hFFFF_FFFF : 64'h8000_0000;
      endcase
      if (i % 4 == 3) ra = 64'h8000_0000;
      do_div(i >= 30, $urandom_range(0, 1) != 0, i >= 30 ? (ra >> 24) | (ra & 64'hFF) : ra,
             i >= 30 ? (rb & 64'hFF) | (rb >> 24 & 64'h80) : rb, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit_seq.md
# div_unit_seq

Parametrised multi-cycle sequential divider for the CPU datapath; the successor to the single-shot 32-bit divide behind ALU opcode 5'b10000. It accepts a dividend/divisor pair on a start pulse and runs a radix-2 restoring iteration, one quotient bit per clock. It supports signed and unsigned modes and flags divide-by-zero. The quotient targets LO and the remainder targets HI, and both are held stable for the control unit's T5 writeback.

## Interface
- WIDTH, 32: operand, quotient and remainder width; legal range 4..64.
- Clock  input  1  rising-edge clock.
- clear_n  input  1  asynchronous, active-low reset.
- start  input  1  request a divide; sampled only in IDLE.
- is_signed  input  1  1 = two's-complement operands; 0 = unsigned. Sampled with start.
- dividend  input  WIDTH  numerator; sampled with start.
- divisor  input  WIDTH  denominator; sampled with start.
- busy  output  1  high from the accepting edge until done deasserts.
- done  output  1  one-cycle pulse; results valid in that cycle.
- quotient  output  WIDTH  result for LO; holds until the next accepted start.
- remainder  output  WIDTH  result for HI; holds until the next accepted start.
- div_by_zero  output  1  high with done when divisor == 0; holds with the results.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE + start:
  - Latch mode.
  - Convert operands to magnitudes: if signed and MSB is set, negate; the result is an unsigned WIDTH-bit magnitude, so |MIN| = 2^(WIDTH-1).
  - Record neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend), both forced to 0 in unsigned mode.
  - Clear the partial remainder and load count = WIDTH.
  - Go to CALC, or to DONE directly if divisor == 0.
- CALC, each cycle:
  - Shift {rem, dvd} left by 1.
  - Trial-subtract the magnitude divisor from the WIDTH+1-bit remainder.
  - If the result is non-negative, keep it and set the quotient LSB to 1; otherwise restore and set it to 0.
  - Decrement count. When count reaches 1, go to FIX on the next edge.
- FIX: negate the quotient if neg_q, negate the remainder if neg_r (truncation toward zero), then go to DONE.
- DONE: done = 1 and results are driven; the next edge returns to IDLE.
- Divide-by-zero: quotient = all ones, remainder = original dividend, div_by_zero = 1. CALC and FIX are skipped.
- Signed overflow MIN / -1: quotient = MIN, remainder = 0. This falls out of the magnitude path with no special case and no flag.
- start while busy is ignored; no queueing and no abort.
- div_by_zero clears at the next accepted start.

## Timing
- Reset (clear_n low, asynchronous): state = IDLE, busy = 0, done = 0, div_by_zero = 0, quotient = 0, remainder = 0, count = 0.
- Reset asserted mid-operation discards the operation; no done is issued.
- Let start be accepted at edge k:
  - busy = 1 from k.
  - Normal divide: done = 1 during the cycle after edge k+WIDTH+1, i.e. latency WIDTH+2 cycles (34 for WIDTH = 32).
  - Divide-by-zero: done follows edge k, i.e. latency 1 cycle.
  - busy and done fall together at the edge after done.
- Back-to-back: the earliest next accept is the edge after done falls, one IDLE cycle minimum. start held high continuously re-triggers at that point.
- quotient and remainder change only at the edge entering DONE.

## Test plan
- Unsigned, WIDTH = 32: 0x12 / 0x14 -> quotient 0x0, remainder 0x12, done exactly 34 cycles after accept. Then 100 / 7 -> quotient 14, remainder 2.
- Signed: -7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Then 7 / -2 -> quotient 0xFFFFFFFD, remainder 0x1.
- Divisor 0, dividend 0x1234 -> done 1 cycle after accept, quotient 0xFFFFFFFF, remainder 0x1234, div_by_zero = 1. The next normal divide clears the flag.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, div_by_zero = 0.
- Pulse start again mid-CALC -> ignored and results unchanged. Drop clear_n mid-CALC -> all outputs 0 immediately, no done. A fresh start afterwards completes correctly.
- WIDTH = 8: unsigned 0xFF / 0x10 -> quotient 0x0F, remainder 0x0F, latency 10. Signed 0x80 / 0x03 -> quotient 0xD6, remainder 0xFE.
